// File: rtl/frame_strobe_loader_pkg.sv
// frame_strobe_loader_pkg
// Shared definitions for the frame strobe loader: default geometry, the
// header sync byte, header bit-field positions and the loader FSM encoding.
package frame_strobe_loader_pkg;

  localparam int DEFAULT_MAX_FRAMES_PER_COL = 20;
  localparam int DEFAULT_FRAME_BITS_PER_ROW = 32;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Header layout: [31:24] sync, [23:19] column id, [4:0] frame index
  localparam int SYNC_MSB  = 31;
  localparam int SYNC_LSB  = 24;
  localparam int COL_MSB   = 23;
  localparam int COL_LSB   = 19;
  localparam int IDX_MSB   = 4;
  localparam int IDX_LSB   = 0;
  localparam int IDX_WIDTH = IDX_MSB - IDX_LSB + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    SETUP     = 3'd2,
    STROBE    = 3'd3,
    HOLD      = 3'd4
  } state_t;

endpackage

// File: rtl/frame_strobe_loader_decoder.sv
// frame_strobe_decoder
// Combinational index-to-one-hot decoder for the frame write strobes.
// Ports:
//   index   - frame index to decode
//   enable  - when low the output is all-zero
//   onehot  - MaxFramesPerCol-wide one-hot strobe vector
module frame_strobe_decoder
  import frame_strobe_loader_pkg::*;
#(
  parameter int MaxFramesPerCol = DEFAULT_MAX_FRAMES_PER_COL
) (
  input  logic [IDX_WIDTH-1:0]       index,
  input  logic                       enable,
  output logic [MaxFramesPerCol-1:0] onehot
);

  // Loop compare rather than a shift so an out-of-range index simply
  // produces no strobe at all.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      onehot[i] = enable && (index == IDX_WIDTH'(i));
    end
  end

endmodule

// File: rtl/frame_strobe_loader.sv
// frame_strobe_loader
// Accepts header/data word pairs from a valid/ready stream and, when the
// header addresses this column with a legal frame index, drives the data
// word onto FrameData and pulses one FrameStrobe bit for a single cycle,
// with one setup cycle before and one hold cycle after the strobe.
// Ports:
//   CLK, resetn  - clock and asynchronous active-low reset
//   s_valid      - upstream word valid
//   s_ready      - loader can accept a word (IDLE and WAIT_DATA only)
//   s_data       - header or data word
//   FrameData    - registered frame row data to the tile column
//   FrameStrobe  - registered one-hot frame write strobe
//   busy         - high whenever the FSM is outside IDLE
//   err          - sticky protocol error (bad sync or frame index)
module frame_strobe_loader
  import frame_strobe_loader_pkg::*;
#(
  parameter int MaxFramesPerCol = DEFAULT_MAX_FRAMES_PER_COL,
  parameter int FrameBitsPerRow = DEFAULT_FRAME_BITS_PER_ROW,
  parameter int ColID           = 0
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FrameBitsPerRow-1:0] s_data,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err
);

  localparam logic [4:0] COL_ID     = 5'(ColID);
  localparam logic [5:0] FRAME_LIMIT = 6'(MaxFramesPerCol);

  state_t                      state;
  logic                        match_q;
  logic [IDX_WIDTH-1:0]        index_q;
  logic [MaxFramesPerCol-1:0]  strobe_next;

  logic [7:0]                  hdr_sync;
  logic [4:0]                  hdr_col;
  logic [IDX_WIDTH-1:0]        hdr_index;
  logic                        hdr_index_ok;

  assign hdr_sync     = s_data[SYNC_MSB:SYNC_LSB];
  assign hdr_col      = s_data[COL_MSB:COL_LSB];
  assign hdr_index    = s_data[IDX_MSB:IDX_LSB];
  assign hdr_index_ok = {1'b0, hdr_index} < FRAME_LIMIT;

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_decoder (
    .index (index_q),
    .enable(match_q),
    .onehot(strobe_next)
  );

  // Single FSM with registered outputs. s_ready and busy are updated
  // together with the state so they always describe the state being
  // entered. An out-of-range index is folded into the mismatch path, so the
  // following data word is still consumed but nothing is strobed.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      match_q     <= 1'b0;
      index_q     <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      s_ready     <= 1'b1;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            if (hdr_sync != SYNC_BYTE) begin
              err <= 1'b1;
            end else begin
              index_q <= hdr_index;
              if (!hdr_index_ok) begin
                err     <= 1'b1;
                match_q <= 1'b0;
              end else begin
                match_q <= (hdr_col == COL_ID);
              end
              state <= WAIT_DATA;
              busy  <= 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          if (s_valid) begin
            if (match_q) begin
              FrameData <= s_data;
            end
            state   <= SETUP;
            s_ready <= 1'b0;
          end
        end
        SETUP: begin
          FrameStrobe <= strobe_next;
          state       <= STROBE;
        end
        STROBE: begin
          FrameStrobe <= '0;
          state       <= HOLD;
        end
        HOLD: begin
          state   <= IDLE;
          s_ready <= 1'b1;
          busy    <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          FrameStrobe <= '0;
          s_ready     <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
